// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter sharing the common data bus among FU results.
// One registered CDB beat with valid/ready backpressure and mispredict flush.
module cdb_arbiter #(
  parameter int NUM_FU  = 4,
  parameter int BW_DATA = 32,
  parameter int BW_TAG  = 5,
  localparam int BW_SRC = $clog2(NUM_FU)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_flush,
  input  logic [NUM_FU-1:0]         i_fu_valid,
  input  logic [NUM_FU*BW_TAG-1:0]  i_fu_tag,
  input  logic [NUM_FU*BW_DATA-1:0] i_fu_data,
  output logic [NUM_FU-1:0]         o_fu_ready,
  output logic                      o_cdb_valid,
  output logic [BW_TAG-1:0]         o_cdb_tag,
  output logic [BW_DATA-1:0]        o_cdb_data,
  output logic [BW_SRC-1:0]         o_cdb_src,
  input  logic                      i_cdb_ready
);

  logic [BW_SRC-1:0] ptr;
  logic [BW_SRC-1:0] ptr_nxt;
  logic [BW_SRC-1:0] win;
  logic [BW_SRC:0]   idx;
  logic              found;
  logic              load_en;
  logic              grant;

  assign load_en = ~i_flush & (~o_cdb_valid | i_cdb_ready);

  // Scan from ptr upward; explicit wrap so NUM_FU need not be a power of 2.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = {1'b0, ptr} + (BW_SRC+1)'(k);
      if (idx >= (BW_SRC+1)'(NUM_FU))
        idx = idx - (BW_SRC+1)'(NUM_FU);
      if (!found && i_fu_valid[idx[BW_SRC-1:0]]) begin
        found = 1'b1;
        win   = idx[BW_SRC-1:0];
      end
    end
  end

  assign grant = rst_n & load_en & found;

  always_comb begin
    o_fu_ready = '0;
    if (grant)
      o_fu_ready[win] = 1'b1;
  end

  assign ptr_nxt = (win == BW_SRC'(NUM_FU-1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cdb_valid <= 1'b0;
      o_cdb_tag   <= '0;
      o_cdb_data  <= '0;
      o_cdb_src   <= '0;
    end else if (i_flush) begin
      o_cdb_valid <= 1'b0;
    end else if (load_en) begin
      o_cdb_valid <= grant;
      if (grant) begin
        o_cdb_tag  <= i_fu_tag[win*BW_TAG +: BW_TAG];
        o_cdb_data <= i_fu_data[win*BW_DATA +: BW_DATA];
        o_cdb_src  <= win;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scenario tasks plus a scoreboard of expected CDB beats.
// A reference round-robin model predicts grants; a negedge monitor pops beats.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int BD = 32;
  localparam int BT = 5;
  localparam int BS = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_flush = 1'b0;
  logic [N-1:0]    i_fu_valid = '0;
  logic [N*BT-1:0] i_fu_tag = '0;
  logic [N*BD-1:0] i_fu_data = '0;
  logic            i_cdb_ready = 1'b0;
  logic [N-1:0]    o_fu_ready;
  logic            o_cdb_valid;
  logic [BT-1:0]   o_cdb_tag;
  logic [BD-1:0]   o_cdb_data;
  logic [BS-1:0]   o_cdb_src;

  cdb_arbiter #(.NUM_FU(N), .BW_DATA(BD), .BW_TAG(BT)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
    .i_fu_valid(i_fu_valid), .i_fu_tag(i_fu_tag),
    .i_fu_data(i_fu_data), .o_fu_ready(o_fu_ready),
    .o_cdb_valid(o_cdb_valid), .o_cdb_tag(o_cdb_tag),
    .o_cdb_data(o_cdb_data), .o_cdb_src(o_cdb_src),
    .i_cdb_ready(i_cdb_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BS-1:0] src;
    logic [BT-1:0] tag;
    logic [BD-1:0] data;
  } beat_t;

  beat_t         q[$];
  int            errors = 0;
  int            checks = 0;
  int            mptr = 0;
  bit            mvalid = 1'b0;
  int            seq = 0;
  logic [BT-1:0] tg[N];
  logic [BD-1:0] dt[N];

  task automatic drive_fu();
    for (int k = 0; k < N; k++) begin
      i_fu_tag[k*BT +: BT]  = tg[k];
      i_fu_data[k*BD +: BD] = dt[k];
    end
  endtask

  task automatic refresh(input int k);
    seq++;
    tg[k] = BT'(seq * 7 + k);
    dt[k] = $urandom;
    drive_fu();
  endtask

  function automatic int rr(input logic [N-1:0] v, input int p);
    for (int j = 0; j < N; j++) begin
      int x;
      x = (p + j) % N;
      if (v[x]) return x;
    end
    return -1;
  endfunction

  function automatic bit lden();
    return !i_flush && (!mvalid || i_cdb_ready);
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] r;
    int w;
    r = '0;
    if (rst_n && lden()) begin
      w = rr(i_fu_valid, mptr);
      if (w >= 0) r[w] = 1'b1;
    end
    return r;
  endfunction

  // Advance one clock, updating the model and scoreboard on the edge.
  task automatic tick(output int w);
    @(posedge clk);
    w = -1;
    if (rst_n) begin
      if (i_flush) begin
        if (mvalid && !i_cdb_ready) void'(q.pop_front());
        mvalid = 1'b0;
      end else if (lden()) begin
        w = rr(i_fu_valid, mptr);
        mvalid = (w >= 0);
        if (w >= 0) begin
          q.push_back('{BS'(w), tg[w], dt[w]});
          mptr = (w == N-1) ? 0 : w + 1;
        end
      end
    end
    #1;
    if (w >= 0) refresh(w);
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      checks++;
      if (o_cdb_valid !== mvalid) begin
        errors++;
        $display("FAIL cdb_valid: got %b want %b t=%0t",
                 o_cdb_valid, mvalid, $time);
      end
      if (o_cdb_valid && i_cdb_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got src=%0d tag=%h want none",
                   o_cdb_src, o_cdb_tag);
        end else begin
          e = q.pop_front();
          if ({o_cdb_src, o_cdb_tag, o_cdb_data} !== e) begin
            errors++;
            $display("FAIL beat: got %0d/%h/%h want %0d/%h/%h",
                     o_cdb_src, o_cdb_tag, o_cdb_data,
                     e.src, e.tag, e.data);
          end
        end
      end
    end
  end

  task automatic test_reset();
    int w;
    for (int k = 0; k < N; k++) refresh(k);
    i_fu_valid = 4'hF;
    i_cdb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_fu_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ready: got %b want 0000", o_fu_ready);
    end
    checks++;
    if ({o_cdb_valid, o_cdb_tag, o_cdb_data, o_cdb_src} !== '0) begin
      errors++;
      $display("FAIL rst_cdb: got v=%b tag=%h data=%h src=%0d want 0",
               o_cdb_valid, o_cdb_tag, o_cdb_data, o_cdb_src);
    end
    tick(w);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_fu_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_first: got %b want 0001", o_fu_ready);
    end
    tick(w);
    @(negedge clk);
    checks++;
    if (o_fu_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rst_second: got %b want 0010", o_fu_ready);
    end
    tick(w);
    checks++;
    if (o_cdb_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got valid %b want 1", o_cdb_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_cdb_valid !== 1'b0 || o_fu_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid: got v=%b rdy=%b want 0/0000",
               o_cdb_valid, o_fu_ready);
    end
    mvalid = 1'b0;
    mptr = 0;
    q.delete();
    tick(w);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_fairness();
    int w;
    logic [N-1:0] e;
    i_fu_valid = 4'hF;
    i_cdb_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = 4'b0001 << (i % 4);
      @(negedge clk);
      checks++;
      if (o_fu_ready !== e) begin
        errors++;
        $display("FAIL fair%0d: got %b want %b", i, o_fu_ready, e);
      end
      tick(w);
    end
  endtask

  task automatic test_ptr_skip();
    int w;
    logic [N-1:0] v[4];
    logic [N-1:0] e[4];
    v[0] = 4'b1000; e[0] = 4'b1000;
    v[1] = 4'b0100; e[1] = 4'b0100;
    v[2] = 4'b0101; e[2] = 4'b0001;
    v[3] = 4'b0101; e[3] = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      i_fu_valid = v[i];
      @(negedge clk);
      checks++;
      if (o_fu_ready !== e[i]) begin
        errors++;
        $display("FAIL skip%0d: got %b want %b", i, o_fu_ready, e[i]);
      end
      tick(w);
    end
  endtask

  task automatic test_backpressure();
    int w;
    tg[3] = 5'h0A;
    drive_fu();
    i_fu_valid = 4'hF;
    i_cdb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_fu_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_load: got %b want 1000", o_fu_ready);
    end
    tick(w);
    i_cdb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (o_fu_ready !== 4'b0000 || o_cdb_tag !== 5'h0A) begin
        errors++;
        $display("FAIL bp_hold%0d: got rdy=%b tag=%h want 0000/0a",
                 i, o_fu_ready, o_cdb_tag);
      end
      tick(w);
    end
    i_cdb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_fu_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_release: got %b want 0001", o_fu_ready);
    end
    tick(w);
    @(negedge clk);
    checks++;
    if (o_fu_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_next: got %b want 0010", o_fu_ready);
    end
    tick(w);
  endtask

  task automatic test_flush();
    int w;
    i_fu_valid = 4'b0001;
    @(negedge clk);
    tick(w);
    i_fu_valid = 4'b0010;
    i_flush = 1'b1;
    i_cdb_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (o_fu_ready !== 4'b0000) begin
      errors++;
      $display("FAIL flush_gnt: got %b want 0000", o_fu_ready);
    end
    tick(w);
    i_flush = 1'b0;
    @(negedge clk);
    checks++;
    if (o_cdb_valid !== 1'b0 || o_fu_ready !== 4'b0010) begin
      errors++;
      $display("FAIL flush_after: got v=%b rdy=%b want 0/0010",
               o_cdb_valid, o_fu_ready);
    end
    tick(w);
  endtask

  task automatic test_idle();
    int w;
    i_fu_valid = 4'b0000;
    i_cdb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_fu_ready !== 4'b0000) begin
      errors++;
      $display("FAIL idle_gnt: got %b want 0000", o_fu_ready);
    end
    tick(w);
    for (int i = 0; i < 2; i++) tick(w);
    checks++;
    if (o_cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: got %b want 0", o_cdb_valid);
    end
    i_fu_valid = 4'hF;
    @(negedge clk);
    checks++;
    if (o_fu_ready !== 4'b0100) begin
      errors++;
      $display("FAIL idle_ptr: got %b want 0100", o_fu_ready);
    end
    tick(w);
  endtask

  task automatic test_back_to_back();
    int w;
    for (int i = 0; i < 300; i++) begin
      i_cdb_ready = ($urandom_range(3) != 0);
      i_flush = ($urandom_range(15) == 0);
      @(negedge clk);
      checks++;
      if (o_fu_ready !== exp_gnt()) begin
        errors++;
        $display("FAIL rand%0d: got %b want %b",
                 i, o_fu_ready, exp_gnt());
      end
      tick(w);
      if (w >= 0 && $urandom_range(1) == 1) i_fu_valid[w] = 1'b0;
      i_fu_valid = i_fu_valid | N'($urandom_range(15));
    end
    i_fu_valid = '0;
    i_flush = 1'b0;
    i_cdb_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick(w);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_ptr_skip();
    test_backpressure();
    test_flush();
    test_idle();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter that shares the single common data bus (CDB) among NUM_FU functional-unit result ports in the Tomasulo backend.
- Each cycle it grants at most one valid FU result. It captures the result into a one-entry registered CDB output stage with valid/ready backpressure.
- The CDB output feeds the reservation stations, register status table and ROB.
- Grant fairness uses true round-robin: after a grant, priority moves to the index after the winner.

Parameters:
NUM_FU, 4, number of functional-unit requesters (>=2)
BW_DATA, 32, result data width
BW_TAG, 5, ROB/RS tag width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_flush  input  1  mispredict flush; kills the CDB stage and blocks grants this cycle
i_fu_valid  input  NUM_FU  result valid per FU
i_fu_tag  input  NUM_FU*BW_TAG  per-FU tag; FU k at bits [k*BW_TAG +: BW_TAG]
i_fu_data  input  NUM_FU*BW_DATA  per-FU data, same packing
o_fu_ready  output  NUM_FU  one-hot grant; a result transfers when i_fu_valid[k] & o_fu_ready[k]
o_cdb_valid  output  1  CDB broadcast valid (registered)
o_cdb_tag  output  BW_TAG  broadcast tag (registered)
o_cdb_data  output  BW_DATA  broadcast data (registered)
o_cdb_src  output  $clog2(NUM_FU)  index of the FU that produced the broadcast (registered)
i_cdb_ready  input  1  consumer accepts the CDB beat this cycle

Behaviour:
- Reset (async, rst_n=0):
  - o_cdb_valid=0, o_cdb_tag=0, o_cdb_data=0, o_cdb_src=0.
  - Priority pointer ptr=0.
  - o_fu_ready=0 while in reset.
- Load enable: load_en = ~i_flush & (~o_cdb_valid | i_cdb_ready).
- Grant (combinational):
  - If load_en=0, o_fu_ready is all zeros.
  - Otherwise, scan i_fu_valid starting at index ptr, ascending, wrapping NUM_FU-1 -> 0.
  - The first set bit wins; o_fu_ready is one-hot at the winner.
  - If no valid bit is set, o_fu_ready is all zeros.
  - o_fu_ready never depends on i_fu_ready-style feedback; no combinational path from o_fu_ready back to i_fu_valid is permitted.
- Pointer update (registered): on any cycle with a grant to winner w, ptr <= (w==NUM_FU-1) ? 0 : w+1. Otherwise ptr holds, including during flush or stall.
- Output stage (registered):
  - Grant to w: next cycle o_cdb_valid=1 with tag/data/src taken from FU w. Latency is exactly one cycle from handshake to broadcast.
  - load_en=1 with no grant: o_cdb_valid <= 0. Tag, data and src may hold.
  - load_en=0 without flush (o_cdb_valid=1, i_cdb_ready=0): all CDB outputs hold unchanged.
  - i_flush=1: o_cdb_valid <= 0 next cycle regardless of i_cdb_ready. No grant that cycle. ptr unchanged.
- Throughput: one beat per cycle sustained when i_cdb_ready=1 (pipelined; reload on the same cycle the current beat is accepted).
- FU contract: an FU holds valid, tag and data stable until granted. The arbiter drops nothing and duplicates nothing.
- Reset mid-operation: outputs and ptr return to reset values immediately. The in-flight beat is discarded.
- Winner index encoding: one-hot to binary, a zero-padded $clog2(NUM_FU)-bit value.
- NUM_FU need not be a power of 2; wrap uses an explicit compare, not modulo truncation.

Test Plan:
1. Reset: assert rst_n=0 mid-stream with o_cdb_valid=1 -> o_cdb_valid=0, o_fu_ready=0 immediately. After release, the first grant goes to FU0 when all are valid.
2. Fairness: i_fu_valid=4'b1111 held, i_cdb_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles. o_cdb_src follows one cycle later, and o_cdb_tag matches each FU's tag.
3. Pointer skip: only FU2 valid from ptr=0 -> grant FU2, ptr=3. Then i_fu_valid=4'b0101 -> grant FU0 (scan 3,0), ptr=1. Next grant is FU2.
4. Backpressure: o_cdb_valid=1 with tag 5'h0A and i_cdb_ready=0 for 3 cycles while all FUs are valid -> o_fu_ready=0 and outputs hold 0x0A. On i_cdb_ready=1, the next winner is loaded in the same cycle and ptr advances by one grant only.
5. Flush: i_flush=1 while o_cdb_valid=1 and FU1 valid with ptr=1 -> no grant, o_cdb_valid=0 next cycle, ptr stays 1. The following cycle FU1 is granted.
6. Idle: i_fu_valid=0 with i_cdb_ready=1 -> o_cdb_valid drops to 0 after the last beat is accepted, and ptr is unchanged.
